// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) and the counter type used by
// every timing axis.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_VISIBLE_AREA = 640;
  localparam int H_FRONT_PORCH  = 16;
  localparam int H_SYNC_PULSE   = 96;
  localparam int H_BACK_PORCH   = 48;

  localparam int V_VISIBLE_AREA = 480;
  localparam int V_FRONT_PORCH  = 10;
  localparam int V_SYNC_PULSE   = 2;
  localparam int V_BACK_PORCH   = 33;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: wrapping counter plus registered blank/sync decode taken
// from the next-state count, so decodes line up with the count register.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int TOTAL   = 800
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic en,
  output logic wrap,
  output logic mark_nxt,
  output logic blank,
  output logic sync_n
`ifdef VGA_TIMING_POS_EN
  ,
  output cnt_t pos
`endif
);

  localparam cnt_t LAST     = cnt_t'(TOTAL - 1);
  localparam cnt_t VIS      = cnt_t'(VISIBLE);
  localparam cnt_t SYNC_ON  = cnt_t'(VISIBLE + FRONT);
  localparam cnt_t SYNC_OFF = cnt_t'(VISIBLE + FRONT + SYNC);

  cnt_t cnt;
  cnt_t cnt_nxt;
  logic at_last;

  always_comb begin
    at_last = (cnt == LAST);
    wrap    = en & at_last;
    cnt_nxt = cnt;
    if (en) cnt_nxt = at_last ? '0 : cnt + cnt_t'(1);
    mark_nxt = (cnt_nxt == VIS);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      cnt    <= '0;
      blank  <= 1'b0;
      sync_n <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      blank  <= (cnt_nxt >= VIS);
      sync_n <= !((cnt_nxt >= SYNC_ON) && (cnt_nxt < SYNC_OFF));
    end
  end

`ifdef VGA_TIMING_POS_EN
  assign pos = cnt;
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/line counters with zero-skew registered
// sync, blank and line/frame pulses. VGA_TIMING_POS_EN adds o_HPos/o_VPos.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_AREA,
  parameter int H_FRONT   = H_FRONT_PORCH,
  parameter int H_SYNC    = H_SYNC_PULSE,
  parameter int H_BACK    = H_BACK_PORCH,
  parameter int V_VISIBLE = V_VISIBLE_AREA,
  parameter int V_FRONT   = V_FRONT_PORCH,
  parameter int V_SYNC    = V_SYNC_PULSE,
  parameter int V_BACK    = V_BACK_PORCH
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  output logic o_HSync,
  output logic o_VSync,
  output logic o_HBlank,
  output logic o_VBlank,
  output logic o_HReset,
  output logic o_VReset
`ifdef VGA_TIMING_POS_EN
  ,
  output cnt_t o_HPos,
  output cnt_t o_VPos
`endif
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic h_wrap, h_mark_nxt, v_mark_nxt;
  logic v_wrap_unused;  // nothing downstream needs the frame carry

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .TOTAL(HT)
  ) u_h (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .en       (1'b1),
    .wrap     (h_wrap),
    .mark_nxt (h_mark_nxt),
    .blank    (o_HBlank),
    .sync_n   (o_HSync)
`ifdef VGA_TIMING_POS_EN
    ,
    .pos      (o_HPos)
`endif
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .TOTAL(VT)
  ) u_v (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .en       (h_wrap),
    .wrap     (v_wrap_unused),
    .mark_nxt (v_mark_nxt),
    .blank    (o_VBlank),
    .sync_n   (o_VSync)
`ifdef VGA_TIMING_POS_EN
    ,
    .pos      (o_VPos)
`endif
  );

  // Pulses come from next-state marks so they land with the counters.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      o_HReset <= 1'b0;
      o_VReset <= 1'b0;
    end else begin
      o_HReset <= h_mark_nxt;
      o_VReset <= h_mark_nxt & v_mark_nxt;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33 (all in lines).
REQ-007 SHALL have port i_Clk, input, 1, pixel clock; the only clock.
REQ-008 SHALL have port i_Reset_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port o_HSync, output, 1, horizontal sync, active-low.
REQ-010 SHALL have port o_VSync, output, 1, vertical sync, active-low.
REQ-011 SHALL have port o_HBlank, output, 1, high outside the visible columns.
REQ-012 SHALL have port o_VBlank, output, 1, high outside the visible lines.
REQ-013 SHALL have port o_HReset, output, 1, one-clock pulse per line.
REQ-014 SHALL have port o_VReset, output, 1, one-clock pulse per frame.

Function
REQ-015 SHALL keep column counter h (0..HT-1, HT = H_VISIBLE+H_FRONT+H_SYNC+H_BACK) and line counter v (0..VT-1, VT analogous); h and v are 10 bits wide.
REQ-016 SHALL increment h every clock; at h = HT-1, h wraps to 0 and v increments; at v = VT-1 with h = HT-1, v wraps to 0.
REQ-017 SHALL register all outputs so that, in any cycle, the outputs reflect the (h,v) held in the counters in that same cycle (decode from next-state values; zero visible skew between outputs).
REQ-018 SHALL drive o_HBlank = (h >= H_VISIBLE) and o_VBlank = (v >= V_VISIBLE).
REQ-019 SHALL drive o_HSync low exactly when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, else high.
REQ-020 SHALL drive o_VSync low exactly when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, else high; transitions occur at h = 0.
REQ-021 SHALL pulse o_HReset high for exactly one clock at h = H_VISIBLE (first blank column) on every line, including lines in vertical blanking.
REQ-022 SHALL pulse o_VReset high for exactly one clock at (h = H_VISIBLE, v = V_VISIBLE), coincident with that line's o_HReset, once per frame.
REQ-023 SHALL produce exactly H_VISIBLE clocks per line with o_HBlank low and exactly V_VISIBLE lines per frame with o_VBlank low, so that downstream pixel counters wrap at H_VISIBLE_AREA/V_VISIBLE_AREA.

Reset
REQ-024 SHALL, while i_Reset_n is low at a rising i_Clk edge, load h = 0 and v = 0 and force o_HSync = 1, o_VSync = 1, o_HBlank = 0, o_VBlank = 0, o_HReset = 0, o_VReset = 0.
REQ-025 SHALL, on reset asserted mid-frame (including during a sync or a pulse), abort immediately; no partial pulse continues after the reset edge.
REQ-026 SHALL, on the first clock after reset release, advance to h = 1 with v = 0; the first o_HReset occurs H_VISIBLE-1 clocks after release.

Configuration
REQ-027 SHALL, with VGA_TIMING_POS_EN defined, add outputs o_HPos (10 bits) and o_VPos (10 bits) equal to h and v (registered, aligned to the other outputs), both reset to 0.
REQ-028 SHALL, without VGA_TIMING_POS_EN, omit o_HPos/o_VPos and their logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL take the default visible and total counts from the shared timing constants (H_VISIBLE_AREA, V_VISIBLE_AREA and porch/sync widths defined there); derived totals HT and VT are localparams.
REQ-030 SHALL contain one sub-module, vga_axis_counter (wrapping counter with visible/sync/pulse decode), instantiated once for h and once for v, the v instance enabled by the h wrap.

Verification
REQ-031 SHALL verify: reset released at t0, defaults -> o_HReset first high at clock 639 after release, low at all other clocks of line 0.
REQ-032 SHALL verify: run 2 full frames -> period 800 clocks between o_HReset pulses, 420000 clocks between o_VReset pulses, 640 o_HBlank-low clocks per line.
REQ-033 SHALL verify: defaults -> o_HSync low for h 656..751 (96 clocks); o_VSync low for lines 490..491 (1600 clocks).
REQ-034 SHALL verify: o_VReset high -> o_HReset, o_HBlank and o_VBlank also high in the same cycle (h = 640, v = 480).
REQ-035 SHALL verify: i_Reset_n low for 1 clock at h = 700 (inside sync) -> next cycle o_HSync = 1, all outputs at reset values, counting restarts from 0.
REQ-036 SHALL verify: with VGA_TIMING_POS_EN, o_HPos = 799 then 0 across a line wrap and o_VPos = 524 then 0 across a frame wrap.
